// File: rtl/matrix_result_tx.sv
// Serialises the systolic multiplier's result matrix over an 8N1 UART line.
// Words go out row-major, each one least-significant byte first; bits go out LSB first.
module matrix_result_tx #(
    parameter int unsigned WORD_WIDTH   = 32,
    parameter int unsigned N_WORDS      = 16,
    parameter int unsigned CLKS_PER_BIT = 832
) (
    input  logic                          uart_clk,
    input  logic                          reset,
    input  logic                          i_start,
    input  logic [N_WORDS*WORD_WIDTH-1:0] i_result,
    output logic                          o_uart_tx,
    output logic                          o_busy,
    output logic                          o_done
);

    localparam int unsigned BYTES_PER_WORD = WORD_WIDTH / 8;
    localparam int unsigned DATA_W         = N_WORDS * WORD_WIDTH;
    localparam int unsigned CNT_W          = $clog2(CLKS_PER_BIT);
    localparam int unsigned WORD_IDX_W     = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int unsigned BYTE_IDX_W     = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                  state;
    logic [DATA_W-1:0]       shadow;
    logic [CNT_W-1:0]        clk_cnt;
    logic [2:0]              bit_idx;
    logic [WORD_IDX_W-1:0]   word_idx;
    logic [BYTE_IDX_W-1:0]   byte_idx;
    logic [7:0]              shift_reg;

    logic                    bit_end;
    logic                    last_byte;
    logic [WORD_IDX_W-1:0]   nxt_word;
    logic [BYTE_IDX_W-1:0]   nxt_byte;
    logic [7:0]              nxt_data;

    // Next byte position (word/byte walk) and the byte it selects from the snapshot
    always_comb begin
        bit_end   = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
        last_byte = (word_idx == WORD_IDX_W'(N_WORDS - 1)) &&
                    (byte_idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));
        nxt_word  = word_idx;
        nxt_byte  = byte_idx + 1'b1;
        if (byte_idx == BYTE_IDX_W'(BYTES_PER_WORD - 1)) begin
            nxt_byte = '0;
            nxt_word = word_idx + 1'b1;
        end
        nxt_data = 8'(shadow >> (32'(nxt_word) * 32'(BYTES_PER_WORD * 8) + 32'(nxt_byte) * 32'd8));
    end

    always_ff @(posedge uart_clk) begin
        if (reset) begin
            state     <= IDLE;
            shadow    <= '0;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            word_idx  <= '0;
            byte_idx  <= '0;
            shift_reg <= '0;
            o_uart_tx <= 1'b1;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    o_uart_tx <= 1'b1;
                    clk_cnt   <= '0;
                    if (i_start) begin
                        shadow    <= i_result;
                        word_idx  <= '0;
                        byte_idx  <= '0;
                        bit_idx   <= '0;
                        shift_reg <= i_result[7:0];
                        o_busy    <= 1'b1;
                        o_uart_tx <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        clk_cnt   <= '0;
                        bit_idx   <= '0;
                        o_uart_tx <= shift_reg[0];
                        state     <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            o_uart_tx <= 1'b1;
                            state     <= STOP;
                        end else begin
                            // Output is registered, so present the bit that follows the current one
                            shift_reg <= shift_reg >> 1;
                            o_uart_tx <= shift_reg[1];
                            bit_idx   <= bit_idx + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (last_byte) begin
                            o_done    <= 1'b1;
                            o_busy    <= 1'b0;
                            o_uart_tx <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            word_idx  <= nxt_word;
                            byte_idx  <= nxt_byte;
                            shift_reg <= nxt_data;
                            o_uart_tx <= 1'b0;
                            state     <= START;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: begin
                    o_uart_tx <= 1'b1;
                    o_busy    <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_result_tx.sv
// Bench for matrix_result_tx: directed frames feed expected-byte and done-cycle queues;
// a line monitor decodes the UART output and checks it against them.
module tb_matrix_result_tx;

    localparam int unsigned WW       = 32;
    localparam int unsigned NW       = 2;
    localparam int unsigned CPB      = 4;
    localparam int unsigned NBYTES   = NW * WW / 8;
    localparam int unsigned TOTAL    = NBYTES * 10 * CPB;

    logic             uart_clk = 1'b0;
    logic             reset    = 1'b1;
    logic             i_start  = 1'b0;
    logic [NW*WW-1:0] i_result = '0;
    logic             o_uart_tx;
    logic             o_busy;
    logic             o_done;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [7:0] exp_bytes[$];
    int         exp_done[$];

    bit         rx_active = 1'b0;
    int         rx_cnt    = 0;
    logic [7:0] rx_byte   = '0;

    matrix_result_tx #(
        .WORD_WIDTH  (WW),
        .N_WORDS     (NW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .uart_clk (uart_clk),
        .reset    (reset),
        .i_start  (i_start),
        .i_result (i_result),
        .o_uart_tx(o_uart_tx),
        .o_busy   (o_busy),
        .o_done   (o_done)
    );

    always #5 uart_clk = ~uart_clk;
    always @(posedge uart_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge uart_clk);
        #1;
    endtask

    // Issue one frame: queue its bytes and the cycle its done pulse must be seen
    task automatic start_frame(input logic [NW*WW-1:0] data);
        i_result = data;
        for (int i = 0; i < int'(NBYTES); i++) exp_bytes.push_back(data[i*8 +: 8]);
        exp_done.push_back(cyc + 1 + int'(TOTAL));
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("start_busy", 32'(o_busy), 32'd1);
        check("start_bit_now", 32'(o_uart_tx), 32'd0);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (o_busy && n < budget) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(o_busy), 32'd0);
        tick();
        tick();
    endtask

    // Line monitor: decodes 8N1 at mid-bit and checks done pulses
    always @(negedge uart_clk) begin
        if (reset) begin
            rx_active = 1'b0;
        end else begin
            if (!rx_active) begin
                if (o_uart_tx === 1'b0) begin
                    rx_active = 1'b1;
                    rx_cnt    = 0;
                end
            end else begin
                rx_cnt++;
            end
            if (rx_active) begin
                if (rx_cnt == int'(CPB / 2))
                    check("start_bit", 32'(o_uart_tx), 32'd0);
                if (rx_cnt >= int'(CPB + CPB / 2) && rx_cnt < int'(9 * CPB) &&
                    ((rx_cnt - int'(CPB / 2)) % int'(CPB)) == 0)
                    rx_byte[3'((rx_cnt - int'(CPB + CPB / 2)) / int'(CPB))] = o_uart_tx;
                if (rx_cnt == int'(9 * CPB + CPB / 2)) begin
                    check("stop_bit", 32'(o_uart_tx), 32'd1);
                    if (exp_bytes.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_byte: got %0h expected none", rx_byte);
                    end else begin
                        check("rx_byte", 32'(rx_byte), 32'(exp_bytes.pop_front()));
                    end
                end
                if (rx_cnt == int'(10 * CPB - 1)) rx_active = 1'b0;
            end
            if (o_done === 1'b1) begin
                if (exp_done.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got pulse at cycle %0d expected none", cyc);
                end else begin
                    check("done_cycle", 32'(cyc), 32'(exp_done.pop_front()));
                end
                check("done_busy", 32'(o_busy), 32'd0);
                check("done_line", 32'(o_uart_tx), 32'd1);
            end
        end
    end

    initial begin
        // Reset held 3 cycles, with a start pulse that must be ignored
        for (int i = 0; i < 3; i++) begin
            i_start = (i == 1);
            tick();
            check("rst_tx", 32'(o_uart_tx), 32'd1);
            check("rst_busy", 32'(o_busy), 32'd0);
            check("rst_done", 32'(o_done), 32'd0);
        end
        i_start = 1'b0;
        reset   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_rst_tx", 32'(o_uart_tx), 32'd1);
            check("post_rst_busy", 32'(o_busy), 32'd0);
        end

        // Byte ordering: word 0 LSB first, then word 1
        start_frame(64'h1122_3344_A1B2_C3D4);
        wait_idle(int'(TOTAL) + 10);

        // Snapshot: input changes one cycle after capture
        start_frame(64'h0000_0002_0000_0001);
        i_result = '1;
        wait_idle(int'(TOTAL) + 10);

        // Start while busy, midway through byte 3
        start_frame(64'h5A5A_0F0F_8001_7E3C);
        repeat (3 * 10 * CPB + 5 * CPB - 1) tick();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("busy_restart_ignored", 32'(o_busy), 32'd1);
        wait_idle(int'(TOTAL) + 10);

        // Back-to-back: new start accepted in the done cycle
        start_frame(64'hDEAD_BEEF_0123_4567);
        begin
            int n = 0;
            while (o_done !== 1'b1 && n < int'(TOTAL) + 10) begin
                tick();
                n++;
            end
        end
        check("b2b_done_seen", 32'(o_done), 32'd1);
        start_frame(64'hCAFE_F00D_89AB_CDEF);
        wait_idle(int'(TOTAL) + 10);

        // Mid-frame reset during word 1 data, then a fresh frame from word 0
        start_frame(64'h7777_6666_5555_4444);
        repeat (4 * 10 * CPB + 10 - 1) tick();
        check("mid_busy", 32'(o_busy), 32'd1);
        reset = 1'b1;
        exp_bytes.delete();
        exp_done.delete();
        tick();
        check("abort_tx", 32'(o_uart_tx), 32'd1);
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_done", 32'(o_done), 32'd0);
        reset = 1'b0;
        repeat (int'(TOTAL)) tick();
        check("abort_stays_idle", 32'(o_busy), 32'd0);
        start_frame(64'h0102_0304_0506_0708);
        wait_idle(int'(TOTAL) + 10);

        check("leftover_bytes", 32'(exp_bytes.size()), 32'd0);
        check("leftover_done", 32'(exp_done.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/matrix_result_tx.md
# matrix_result_tx

Serialises the 4x4 result matrix of the systolic multiplier back to the host over an 8N1 UART line. It sits downstream of the multiplier and is the transmit counterpart of the byte receive path in the top controller. On a start pulse it snapshots all result words and transmits them row-major, each word least-significant byte first. It reports busy and done so the controller can sequence the next load/compute cycle.

## Interface
- WORD_WIDTH, 32: bits per result word; must be a multiple of 8.
- N_WORDS, 16: words per frame set (4x4 matrix).
- CLKS_PER_BIT, 832: uart_clk cycles per UART bit (64 x 13, matching the receive oversampling). Minimum 2.
- uart_clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- i_start  in  1  request to send the whole matrix; sampled every cycle.
- i_result  in  N_WORDS*WORD_WIDTH  flattened results; word k = i_result[k*WORD_WIDTH +: WORD_WIDTH], with k = row*4 + col.
- o_uart_tx  out  1  serial line, idle high.
- o_busy  out  1  high while a transmission is in progress.
- o_done  out  1  one-cycle pulse when the final stop bit completes.

## Operation
- Reset values: o_uart_tx=1, o_busy=0, o_done=0, state IDLE, all counters 0, shadow register 0.
- States: IDLE, START, DATA, STOP.
- IDLE: line high. On i_start=1:
  - copy i_result into the shadow register;
  - clear the word index, byte index and bit index;
  - load the first byte into the shift register;
  - go to START.
- Changes to i_result after capture have no effect on the transmission in progress.
- START: drive 0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: drive the shift register LSB for CLKS_PER_BIT cycles per bit. After bit 7, go to STOP.
- STOP: drive 1 for CLKS_PER_BIT cycles. At the end of STOP:
  - If this was not the last byte: advance the byte index, wrapping at WORD_WIDTH/8 and incrementing the word index on wrap. Load the next byte and go to START.
  - If this was the last byte (word N_WORDS-1, byte WORD_WIDTH/8-1): pulse o_done and go to IDLE.
- Byte order on the line: word 0 byte 0 (bits [7:0]), word 0 byte 1, ..., word N_WORDS-1 byte WORD_WIDTH/8-1. Bits within a byte go LSB first.
- i_start is ignored whenever the state is not IDLE. There is no queueing.
- i_start asserted in the same cycle o_done is high is accepted, because the state is already IDLE.
- Reset mid-transmission aborts immediately: the line returns high on the next edge, no o_done is produced, and the partial frame is discarded.
- Bit-period counter width: $clog2(CLKS_PER_BIT). It wraps to 0 at CLKS_PER_BIT-1.

## Timing
- i_start sampled high at edge k:
  - o_busy=1 and o_uart_tx=0 (start bit) from edge k+1;
  - all outputs are registered, so there is no combinational path from i_start.
- Each bit is exactly CLKS_PER_BIT cycles. Each byte is 10*CLKS_PER_BIT cycles.
- There are no idle cycles between bytes: the next start bit follows the stop bit directly.
- Full transfer: N_WORDS*(WORD_WIDTH/8)*10*CLKS_PER_BIT cycles, running from edge k+1 to the end of the last stop bit.
- At edge k+1+total: o_busy=0 and o_done=1, for one cycle only; o_uart_tx=1.
- Default parameters: 64 bytes x 8320 cycles = 532480 cycles.

## Test plan
- Reset behaviour (CLKS_PER_BIT=4, N_WORDS=2): hold reset 3 cycles -> o_uart_tx=1, o_busy=0, o_done=0 throughout. i_start pulsed during reset -> no transmission.
- Single-word ordering (N_WORDS=1, i_result=32'hA1B2C3D4, CLKS_PER_BIT=4): pulse i_start -> line decodes bytes D4, C3, B2, A1 in order, each bit lasting 4 cycles. o_done rises exactly 160 cycles after the start bit begins.
- Snapshot (N_WORDS=2): start with 64'h0000_0002_0000_0001, change i_result to all ones one cycle later -> received bytes are 01 00 00 00 02 00 00 00.
- Start while busy: pulse i_start again midway through byte 3 -> no restart. Total length and o_done timing are unchanged, and only one o_done pulse occurs.
- Back-to-back: assert i_start in the o_done cycle -> a new start bit appears on the next edge with zero gap.
- Mid-frame reset: assert reset during word 1 DATA -> o_uart_tx=1 on the next edge, o_busy=0, and no o_done. A new i_start then sends from word 0 byte 0.
